spart_bus_arbiter: RTL and testbench

- Shares one SPART processor-side bus (iocs/iorw/ioaddr/databus) between NUM_REQ requester clients, for example the echo loop, a message transmitter and a divisor configurator.
- Each grant runs exactly one single-cycle bus transaction.
- Arbitration is round-robin.
- Transmit-buffer writes are held until TBR is high. Receive-buffer reads are held until RDA is high. A bounded wait timeout aborts a stalled transaction.

---
 rtl/spart_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spart_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spart_bus_arbiter
//  Description : Round-robin arbiter that shares the SPART processor-side bus
//                (iocs/iorw/ioaddr/databus) between NUM_REQ clients. Each
//                grant performs one single-cycle bus transaction, gated on
//                TBR (transmit writes) or RDA (receive reads), with an
//                optional bounded wait that aborts a stalled transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_bus_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int WAIT_MAX = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [2*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic [7:0]             rdata,
    output logic                   busy,
    output logic                   iocs,
    output logic                   iorw,
    output logic [1:0]             ioaddr,
    inout  wire  [7:0]             databus,
    input  logic                   rda,
    input  logic                   tbr
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    // Last counter value before the timeout fires (unused when WAIT_MAX==0).
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_XFER = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q,    rr_d;
    logic            rw_q,    rw_d;
    logic [1:0]      addr_q,  addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            err_q,   err_d;
    logic [7:0]      rdata_q, rdata_d;

    logic            arb_found;
    logic [IW-1:0]   arb_sel;
    logic            gate_open;

    // Round-robin pick: first active request at or after rr+1, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!arb_found && req[(int'(rr_q) + k) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_sel   = IW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    // Transmit writes wait for TBR, receive reads wait for RDA; other
    // registers are always accessible. SPART shares this clock, so no sync.
    always_comb begin
        gate_open = 1'b1;
        if (addr_q == 2'b00) begin
            gate_open = rw_q ? rda : tbr;
        end
    end

    // Next-state and latched-field logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    owner_d = arb_sel;
                    rr_d    = arb_sel;
                    rw_d    = req_rw[arb_sel];
                    addr_d  = req_addr[2*arb_sel +: 2];
                    wdata_d = req_wdata[8*arb_sel +: 8];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_GATE;
                end
            end
            S_GATE: begin
                if (gate_open) begin
                    state_d = S_XFER;
                end else if ((WAIT_MAX != 0) && (cnt_q == WAIT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                if (rw_q) begin
                    rdata_d = databus;
                end
                err_d   = 1'b0;
                state_d = S_ACK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-field registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
            rw_q    <= 1'b0;
            addr_q  <= 2'b00;
            wdata_q <= 8'h00;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus and handshake outputs decode from registered state only.
    always_comb begin
        iocs   = (state_q == S_XFER);
        iorw   = (state_q == S_XFER) ? rw_q   : 1'b0;
        ioaddr = (state_q == S_XFER) ? addr_q : 2'b00;
        busy   = (state_q != S_IDLE);
        ack    = '0;
        if (state_q == S_ACK) begin
            ack[owner_q] = 1'b1;
        end
        err    = (state_q == S_ACK) && err_q;
        rdata  = rdata_q;
    end

    assign databus = ((state_q == S_XFER) && !rw_q) ? wdata_q : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_spart_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spart_bus_arbiter
//  Description : Scoreboard bench for spart_bus_arbiter with a transaction
//                level reference model and a bench-side SPART data source.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_bus_arbiter;

    localparam int N   = 2;
    localparam int WM  = 1023;
    localparam int WM2 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Requester-side stimulus
    logic [N-1:0] rq     = '0;
    logic [N-1:0] rq_rw  = '0;
    logic [1:0]   rq_addr [N];
    logic [7:0]   rq_wd   [N];
    logic [2*N-1:0] req_addr_bus;
    logic [8*N-1:0] req_wdata_bus;
    assign req_addr_bus  = {rq_addr[1], rq_addr[0]};
    assign req_wdata_bus = {rq_wd[1], rq_wd[0]};

    logic       tbr = 1'b1, rda = 1'b1;
    logic [7:0] spart_val = 8'h00;
    logic       rand_on = 1'b0;

    logic [N-1:0] ack;
    logic         err, busy, iocs, iorw;
    logic [7:0]   rdata;
    logic [1:0]   ioaddr;
    wire  [7:0]   databus;
    assign databus = (iocs && iorw) ? spart_val : 8'hzz;

    spart_bus_arbiter #(.NUM_REQ(N), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .req(rq), .req_rw(rq_rw),
        .req_addr(req_addr_bus), .req_wdata(req_wdata_bus),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .rda(rda), .tbr(tbr)
    );

    // Second instance with a short timeout and a permanently stalled SPART.
    logic [N-1:0]   t_req = '0, t_rw = '0;
    logic [2*N-1:0] t_addr = '0;
    logic [8*N-1:0] t_wd = '0;
    logic [N-1:0]   t_ack;
    logic           t_err, t_busy, t_iocs, t_iorw;
    logic [7:0]     t_rdata;
    logic [1:0]     t_ioaddr;
    wire  [7:0]     t_databus;
    logic           t_low = 1'b0;

    spart_bus_arbiter #(.NUM_REQ(N), .WAIT_MAX(WM2)) dut_to (
        .clk(clk), .rst(rst), .req(t_req), .req_rw(t_rw),
        .req_addr(t_addr), .req_wdata(t_wd),
        .ack(t_ack), .err(t_err), .rdata(t_rdata), .busy(t_busy),
        .iocs(t_iocs), .iorw(t_iorw), .ioaddr(t_ioaddr), .databus(t_databus),
        .rda(t_low), .tbr(t_low)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct { bit rw; bit [1:0] addr; bit [7:0] wd; } txn_t;
    typedef struct { int c; int owner; bit rw; bit [1:0] addr; bit [7:0] wd; } xexp_t;
    typedef struct { int c; int owner; bit err; bit [7:0] rdata; } aexp_t;

    txn_t  pend0[$];
    txn_t  pend1[$];
    xexp_t exp_x[$];
    aexp_t exp_a[$];
    bit    m_busy  = 1'b0;
    bit [7:0] m_rdata = 8'h00;

    // Requester driver: a free requester raises its next pending request.
    initial begin : drv
        txn_t t;
        forever begin
            @(posedge clk); #1;
            if (!rq[0] && pend0.size() > 0) begin
                t = pend0.pop_front();
                rq_rw[0] = t.rw; rq_addr[0] = t.addr; rq_wd[0] = t.wd; rq[0] = 1'b1;
            end
            if (!rq[1] && pend1.size() > 0) begin
                t = pend1.pop_front();
                rq_rw[1] = t.rw; rq_addr[1] = t.addr; rq_wd[1] = t.wd; rq[1] = 1'b1;
            end
        end
    end

    // Requesters drop req inside the ack cycle.
    initial begin : dropper
        logic [N-1:0] a;
        forever begin
            @(negedge clk);
            a = ack;
            #1;
            rq = rq & ~a;
        end
    end

    // Random SPART status and read data.
    initial begin : spart_rand
        forever begin
            @(posedge clk); #1;
            if (rand_on) begin
                tbr       = ($urandom_range(0, 3) != 0);
                rda       = ($urandom_range(0, 3) != 0);
                spart_val = 8'($urandom);
            end
        end
    end

    // Reference model: grants rotate among pending requesters; each grant
    // waits for its gate (or the timeout), then a one-cycle transfer and a
    // one-cycle acknowledge; the bus is re-arbitrated the cycle after.
    initial begin : model
        int  last, sel, k;
        bit  done, ab, rw;
        bit [1:0] ad;
        bit [7:0] wd;
        last = N - 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = N - 1; m_busy = 0; m_rdata = 8'h00;
                exp_x.delete(); exp_a.delete();
                continue;
            end
            m_busy = 0;
            if (rq != '0) begin
                sel = -1;
                for (int j = 1; j <= N; j++)
                    if (sel < 0 && rq[(last + j) % N]) sel = (last + j) % N;
                last = sel;
                rw = rq_rw[sel]; ad = rq_addr[sel]; wd = rq_wd[sel];
                done = 0; ab = 0; k = 0;
                while (!done && !ab) begin
                    @(negedge clk);
                    if (rst) ab = 1;
                    else begin
                        m_busy = 1;
                        if (ad != 2'b00 || (rw ? rda : tbr)) begin
                            exp_x.push_back('{cyc + 1, sel, rw, ad, wd});
                            @(negedge clk);
                            if (rst) ab = 1;
                            else begin
                                if (rw) m_rdata = spart_val;
                                exp_a.push_back('{cyc + 1, sel, 1'b0, m_rdata});
                            end
                            done = 1;
                        end else if (k == WM - 1) begin
                            exp_a.push_back('{cyc + 1, sel, 1'b1, m_rdata});
                            done = 1;
                        end else k++;
                    end
                end
                if (!ab) begin
                    @(negedge clk);
                    if (rst) ab = 1;
                end
                if (ab) begin
                    last = N - 1; m_busy = 0; m_rdata = 8'h00;
                    exp_x.delete(); exp_a.delete();
                end
            end
        end
    end

    // Monitor: compares every bus transfer and every acknowledge.
    initial begin : monitor
        xexp_t ex;
        aexp_t ea;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                while (exp_x.size() > 0 && exp_x[0].c < cyc) begin
                    chk("xfer_missing", 32'd0, 32'd1);
                    void'(exp_x.pop_front());
                end
                while (exp_a.size() > 0 && exp_a[0].c < cyc) begin
                    chk("ack_missing", 32'd0, 32'd1);
                    void'(exp_a.pop_front());
                end
                chk("busy", 32'(busy), 32'(m_busy));
                if (iocs) begin
                    if (exp_x.size() == 0 || exp_x[0].c != cyc) chk("unexpected_iocs", 32'd1, 32'd0);
                    else begin
                        ex = exp_x.pop_front();
                        chk("iorw", 32'(iorw), 32'(ex.rw));
                        chk("ioaddr", 32'(ioaddr), 32'(ex.addr));
                        chk("databus", 32'(databus), ex.rw ? 32'(spart_val) : 32'(ex.wd));
                    end
                end else if (ioaddr != 2'b00 || iorw) chk("idle_bus", {30'd0, iorw, |ioaddr}, 32'd0);
                if (ack != '0 || err) begin
                    if (exp_a.size() == 0 || exp_a[0].c != cyc) chk("unexpected_ack", 32'(ack), 32'd0);
                    else begin
                        ea = exp_a.pop_front();
                        chk("ack_vec", 32'(ack), 32'd1 << ea.owner);
                        chk("err", 32'(err), 32'(ea.err));
                        chk("rdata", 32'(rdata), 32'(ea.rdata));
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int j;
        for (j = 0; j < 3000; j++) begin
            @(negedge clk); #3;
            if (pend0.size() == 0 && pend1.size() == 0 && rq == '0 &&
                exp_x.size() == 0 && exp_a.size() == 0 && !m_busy) break;
        end
        if (j >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL %s_idle_timeout: got busy required idle", nm);
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g_c, a_c, i_c;
        bit saw;
        rq_addr[0] = 2'b00; rq_addr[1] = 2'b00; rq_wd[0] = 8'h00; rq_wd[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #2;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_iocs", 32'(iocs), 32'd0);
        chk("rst_ioaddr", 32'(ioaddr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Divisor configuration writes from requester 0
        pend0.push_back('{1'b0, 2'b10, 8'h45});
        pend0.push_back('{1'b0, 2'b11, 8'h01});
        wait_idle("divisor");

        // Both requesters continuously requesting
        for (int j = 0; j < 4; j++) begin
            pend0.push_back('{1'b0, 2'b10, 8'(8'h10 + j)});
            pend1.push_back('{1'b0, 2'b10, 8'(8'h20 + j)});
        end
        wait_idle("round_robin");

        // Transmit write stalled on TBR
        tbr = 1'b0;
        pend1.push_back('{1'b0, 2'b00, 8'h41});
        repeat (20) @(posedge clk);
        #1 tbr = 1'b1;
        wait_idle("tbr_gate");

        // Receive read stalled on RDA
        rda = 1'b0; spart_val = 8'h5A;
        pend0.push_back('{1'b1, 2'b00, 8'h00});
        repeat (5) @(posedge clk);
        #1 rda = 1'b1;
        wait_idle("rda_read");
        chk("rdata_after_read", 32'(rdata), 32'h5A);

        // Reset while requester 1 waits on RDA
        rda = 1'b0;
        pend1.push_back('{1'b1, 2'b00, 8'h00});
        for (int j = 0; j < 50 && !busy; j++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_iocs", 32'(iocs), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        pend0.push_back('{1'b0, 2'b10, 8'hA5});
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rda = 1'b1; spart_val = 8'h3C;
        wait_idle("after_reset");

        // Randomized traffic with random SPART status
        rand_on = 1'b1;
        for (int j = 0; j < 60; j++) begin
            txn_t t;
            t.rw = 1'($urandom); t.addr = 2'($urandom); t.wd = 8'($urandom);
            if ($urandom_range(0, 1) == 0) pend0.push_back(t);
            else pend1.push_back(t);
        end
        wait_idle("random");
        rand_on = 1'b0; tbr = 1'b1; rda = 1'b1;

        // Timeout on the short-timeout instance
        @(posedge clk); #1;
        i_c = cyc;
        t_req = 2'b01; t_rw = 2'b00; t_addr = 4'b0000; t_wd = 16'h0033;
        g_c = -1; a_c = -1; saw = 0;
        for (int j = 0; j < 40 && a_c < 0; j++) begin
            @(negedge clk); #2;
            if (t_busy && g_c < 0) g_c = cyc;
            if (t_iocs) saw = 1;
            if (t_ack != '0) begin
                a_c = cyc;
                chk("to_ack_vec", 32'(t_ack), 32'd1);
                chk("to_err", 32'(t_err), 32'd1);
                t_req = '0;
            end
        end
        t_req = '0;
        chk("to_gate_entry", 32'(g_c - i_c), 32'd1);
        chk("to_latency", 32'(a_c - g_c), 32'(WM2));
        chk("to_iocs", 32'(saw), 32'd0);
        chk("to_rdata", 32'(t_rdata), 32'd0);
        @(negedge clk); #2;
        chk("to_idle", 32'(t_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
